// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector pair loader slice.
// Holds the default element width and pair capacity, the derived address
// width, the loader FSM state encoding and a small address-range helper.
package vec_pkg;

    localparam int VEC_W_DEF     = 32;
    localparam int VEC_DEPTH_DEF = 16;
    localparam int VEC_AW_DEF    = $clog2(VEC_DEPTH_DEF);

    // Loader sequencing: clear, accept pairs, hand to kernel, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } vec_state_e;

    // True when a kernel read address falls inside the loaded region.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] len);
        return (addr < len);
    endfunction

endpackage

// File: rtl/vec_pair_mem.sv
// vec_pair_mem: paired element storage for the loader.
// Two W-bit arrays (a and b) share one write port and address; each array
// has its own asynchronous read port so the kernel can fetch a[i] and b[j]
// in the same cycle. Contents are deliberately not reset.
module vec_pair_mem
    import vec_pkg::*;
#(
    parameter int W     = VEC_W_DEF,
    parameter int DEPTH = VEC_DEPTH_DEF,
    parameter int AW    = VEC_AW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata_a,
    input  logic [W-1:0]  wdata_b,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] mem_a [DEPTH];
    logic [W-1:0] mem_b [DEPTH];

    // Store an accepted pair at the current fill index.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_a[waddr] <= wdata_a;
            mem_b[waddr] <= wdata_b;
        end
    end

    assign rdata_a = mem_a[raddr_a];
    assign rdata_b = mem_b[raddr_b];

endmodule

// File: rtl/vec_pair_loader.sv
// vec_pair_loader: buffers a vector of (a[i], b[i]) pairs from a streaming
// input, starts a kernel on the loaded vector, serves the kernel's reads and
// returns its result on a valid/ready output.
// Optional feature: define VEC_PAIR_LOADER_RANGE_CHECK_EN to return zero for
// reads at or beyond k_len and raise a sticky err flag; without it err is
// tied low and read addresses are simply truncated to the memory width.
module vec_pair_loader
    import vec_pkg::*;
#(
    parameter int DEPTH = VEC_DEPTH_DEF,
    parameter int W     = VEC_W_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_a,
    input  logic [W-1:0]  s_b,
    input  logic          s_last,
    output logic          k_start,
    output logic [AW:0]   k_len,
    input  logic [31:0]   a_addr,
    input  logic [31:0]   b_addr,
    input  logic          a_rd_en,
    input  logic          b_rd_en,
    output logic [W-1:0]  a_in,
    output logic [W-1:0]  b_in,
    input  logic [W-1:0]  k_result,
    input  logic          k_done,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_result,
    output logic [AW:0]   m_len,
    output logic          err
);

    localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    vec_state_e   state_q, state_d;
    logic [AW:0]  cnt_q, cnt_d;
    logic         s_ready_q, s_ready_d;
    logic         k_start_q, k_start_d;
    logic         m_valid_q, m_valid_d;
    logic [W-1:0] m_result_q, m_result_d;
    logic [AW:0]  m_len_q, m_len_d;

    logic         wr_s;
    logic         cnt_full_s;
    logic         capture_s;
    logic         handshake_s;
    logic [W-1:0] mem_rd_a_s;
    logic [W-1:0] mem_rd_b_s;

    // A pair is written only while loading and only on a real handshake;
    // s_valid in any other state is dropped.
    assign wr_s        = (state_q == LOAD) && s_valid && s_ready_q;
    // The pair being accepted fills the last slot, so s_last is irrelevant.
    assign cnt_full_s  = (cnt_q == LAST_IDX);
    // A done seen in the k_start cycle belongs to a previous kernel run.
    assign capture_s   = (state_q == RUN) && k_done && !k_start_q;
    assign handshake_s = m_valid_q && m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (wr_s && (s_last || cnt_full_s)) begin
                    state_d = RUN;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (capture_s) begin
                    state_d = OUT;
                end else begin
                    state_d = RUN;
                end
            end
            OUT: begin
                if (handshake_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: flags are computed from the upcoming state so that
    // every handshake/control output leaves a flop.
    always_comb begin
        s_ready_d = 1'b0;
        k_start_d = 1'b0;
        m_valid_d = 1'b0;
        case (state_d)
            LOAD: begin
                s_ready_d = 1'b1;
            end
            RUN: begin
                if (state_q == LOAD) begin
                    k_start_d = 1'b1;
                end else begin
                    k_start_d = 1'b0;
                end
            end
            OUT: begin
                m_valid_d = 1'b1;
            end
            default: begin
                s_ready_d = 1'b0;
            end
        endcase
    end

    // Fill counter: cleared in IDLE, bumped per accepted pair, then held as
    // the vector length for the kernel and the result.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = CNT_ZERO;
        end else if (wr_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Result capture: held until the consumer takes it.
    always_comb begin
        m_result_d = m_result_q;
        m_len_d    = m_len_q;
        if (capture_s) begin
            m_result_d = k_result;
            m_len_d    = cnt_q;
        end else begin
            m_result_d = m_result_q;
            m_len_d    = m_len_q;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= CNT_ZERO;
            s_ready_q  <= 1'b0;
            k_start_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_result_q <= {W{1'b0}};
            m_len_q    <= CNT_ZERO;
        end else begin
            cnt_q      <= cnt_d;
            s_ready_q  <= s_ready_d;
            k_start_q  <= k_start_d;
            m_valid_q  <= m_valid_d;
            m_result_q <= m_result_d;
            m_len_q    <= m_len_d;
        end
    end

    vec_pair_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we      (wr_s),
        .waddr   (cnt_q[AW-1:0]),
        .wdata_a (s_a),
        .wdata_b (s_b),
        .raddr_a (a_addr[AW-1:0]),
        .raddr_b (b_addr[AW-1:0]),
        .rdata_a (mem_rd_a_s),
        .rdata_b (mem_rd_b_s)
    );

`ifdef VEC_PAIR_LOADER_RANGE_CHECK_EN
    logic        a_oor_s;
    logic        b_oor_s;
    logic        err_q, err_d;
    logic [31:0] len_ext_s;

    // Compare the full 32-bit address so aliasing addresses are caught too.
    assign len_ext_s = 32'(cnt_q);
    assign a_oor_s   = a_rd_en && !addr_in_range(a_addr, len_ext_s);
    assign b_oor_s   = b_rd_en && !addr_in_range(b_addr, len_ext_s);

    // Kernel read data: zero when disabled or outside the loaded vector.
    always_comb begin
        a_in = {W{1'b0}};
        b_in = {W{1'b0}};
        if (a_rd_en && !a_oor_s) begin
            a_in = mem_rd_a_s;
        end else begin
            a_in = {W{1'b0}};
        end
        if (b_rd_en && !b_oor_s) begin
            b_in = mem_rd_b_s;
        end else begin
            b_in = {W{1'b0}};
        end
    end

    // Error accumulates any out-of-range read; only reset clears it.
    always_comb begin
        err_d = err_q | a_oor_s | b_oor_s;
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_addr_hi_s;

    // Kernel read data: zero when disabled, otherwise the truncated index.
    always_comb begin
        a_in = {W{1'b0}};
        b_in = {W{1'b0}};
        if (a_rd_en) begin
            a_in = mem_rd_a_s;
        end else begin
            a_in = {W{1'b0}};
        end
        if (b_rd_en) begin
            b_in = mem_rd_b_s;
        end else begin
            b_in = {W{1'b0}};
        end
    end

    // Upper address bits are intentionally ignored in this build.
    assign unused_addr_hi_s = ^{a_addr[31:AW], b_addr[31:AW]};
    assign err              = 1'b0;
`endif

    assign s_ready  = s_ready_q;
    assign k_start  = k_start_q;
    assign k_len    = cnt_q;
    assign m_valid  = m_valid_q;
    assign m_result = m_result_q;
    assign m_len    = m_len_q;

endmodule

// File: doc/vec_pair_loader.md
VEC_PAIR_LOADER -- requirements
Module: vec_pair_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning element-pair capacity (power of 2, 2..256).
REQ-002 SHALL have parameter W, default 32, meaning element and result width.
REQ-003 clk  in  1  clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 s_valid  in  1  input pair valid.
REQ-006 s_ready  out  1  loader accepts a pair.
REQ-007 s_a, s_b  in  W  element a[i], b[i].
REQ-008 s_last  in  1  final pair of the vector.
REQ-009 k_start  out  1  one-cycle kernel start pulse.
REQ-010 k_len  out  AW+1  loaded pair count, stable while the kernel runs.
REQ-011 a_addr, b_addr  in  32  kernel read addresses.
REQ-012 a_rd_en, b_rd_en  in  1  kernel read enables.
REQ-013 a_in, b_in  out  W  read data.
REQ-014 k_result  in  W  kernel result.
REQ-015 k_done  in  1  kernel done, level or pulse.
REQ-016 m_valid  out  1  result valid.
REQ-017 m_ready  in  1  result accepted.
REQ-018 m_result  out  W  captured result.
REQ-019 m_len  out  AW+1  pair count belonging to m_result.
REQ-020 err  out  1  sticky out-of-range read flag.

Function
REQ-021 FSM SHALL have states IDLE, LOAD, RUN and OUT; reset state SHALL be IDLE.
REQ-022 IDLE SHALL clear the count and move to LOAD on the next cycle.
REQ-023 LOAD: s_ready SHALL be 1; on s_valid&s_ready, the pair SHALL be written to mem[cnt] and cnt incremented.
REQ-024 LOAD exit on an accepted pair with s_last, or on the accepted pair that makes cnt==DEPTH (s_last ignored), SHALL go to RUN; s_ready SHALL be 0 the cycle after.
REQ-025 A one-pair vector (s_last on the first beat) SHALL give k_len=1.
REQ-026 k_start SHALL pulse exactly 1 cycle, on the first cycle of RUN; k_len SHALL hold cnt through RUN and OUT.
REQ-027 Read ports SHALL be combinational: a_in = a_rd_en ? mem_a[a_addr[AW-1:0]] : 0; likewise b_in; the kernel samples in the same cycle.
REQ-028 k_done SHALL be ignored outside RUN, and also in the k_start cycle.
REQ-029 RUN with k_done=1 SHALL capture k_result into m_result and cnt into m_len, then go to OUT.
REQ-030 OUT: m_valid SHALL be 1, with m_result and m_len stable until m_valid&m_ready.
REQ-031 On m_valid&m_ready, the FSM SHALL go to IDLE; s_ready SHALL rise 2 cycles later (IDLE then LOAD).
REQ-032 s_valid outside LOAD SHALL be ignored, with no write.
REQ-033 Memory SHALL not be cleared between vectors; stale entries beyond k_len are undefined to the kernel.

Reset
REQ-034 Reset SHALL force IDLE, cnt=0, k_start=0, m_valid=0, m_result=0, m_len=0, err=0 and s_ready=0; memory contents are not reset.
REQ-035 Reset asserted mid-LOAD/RUN/OUT SHALL abort the vector; the result SHALL not be emitted.

Configuration
REQ-036 Macro VEC_PAIR_LOADER_RANGE_CHECK_EN:
- defined: a read with rd_en=1 and addr>=k_len SHALL return 0 and set err (sticky until reset).
- undefined: no check, err tied to 0, and the address is truncated to AW bits.

Structure
REQ-037 Shared package vec_pkg SHALL hold the W default, DEPTH default, AW=$clog2(DEPTH), and the FSM state enum.
REQ-038 One sub-module, vec_pair_mem (dual W-bit array, 1 write port, 2 async read ports), SHALL be instantiated once.

Verification
REQ-039 Load 4 pairs a={1,2,3,4}, b={5,6,7,8} with s_last on beat 4 -> k_start pulse; k_len=4; reads at addr 2 return 3/7; k_result=70 with k_done -> m_valid, m_result=70, m_len=4.
REQ-040 Send 17 pairs with DEPTH=16 and no s_last -> 16 accepted, s_ready=0 on the 17th, k_len=16.
REQ-041 Single pair (9,9) with s_last -> k_len=1; k_done -> m_result=k_result, m_len=1.
REQ-042 Hold m_ready=0 for 5 cycles in OUT -> m_valid and m_result stable; m_ready=1 -> IDLE, s_ready=1 two cycles later.
REQ-043 Assert rst_n=0 after 2 LOAD beats -> all outputs at reset values; next vector loads from index 0.
REQ-044 With the macro defined, k_len=3 and a read at addr 5 -> a_in=0, err=1 and held; without the macro -> err stays 0.
